// File: rtl/led_seq_ctrl.sv
// Autonomous LED pattern sequencer: CPU-loaded patterns are replayed to the PIO data register, one per period.
// First strobe one cycle after EN is written; master strobe holds under m_waitrequest and is never aborted.
module led_seq_ctrl #(
    parameter int PATTERN_DEPTH = 8,
    parameter int PERIOD_W      = 24,
    parameter int DATA_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy
);
    localparam int IDX_W = (PATTERN_DEPTH > 1) ? $clog2(PATTERN_DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(PATTERN_DEPTH);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                en_q, en_d, oneshot_q, oneshot_d;
    logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic [4:0]          length_q, length_d;
    logic [DATA_W-1:0]   pat_q [PATTERN_DEPTH];
    logic [DATA_W-1:0]   pat_d [PATTERN_DEPTH];
    logic [3:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic                m_cs_q, m_cs_d, m_wn_q, m_wn_d;
    logic [DATA_W-1:0]   m_wdat_q, m_wdat_d;

    logic                cfg_wr, ctrl_wr, pat_hit, en_eff, last_step;
    logic [IDX_W-1:0]    pat_sel;
    logic [PERIOD_W-1:0] period_eff;
    logic [4:0]          len_eff;
    logic                unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_writedata;

    assign cfg_wr   = cfg_chipselect & ~cfg_write_n;
    assign ctrl_wr  = cfg_wr && (cfg_address == 5'd0);
    assign pat_hit  = cfg_address[4] && ({1'b0, cfg_address[3:0]} < DEPTH5);
    assign pat_sel  = cfg_address[IDX_W-1:0];
    // A CTRL write in flight overrides the stored EN so start/stop act without an extra cycle.
    assign en_eff   = ctrl_wr ? cfg_writedata[0] : en_q;

    assign period_eff = (period_q == '0) ? PERIOD_ONE : period_q;
    assign len_eff    = (length_q == 5'd0) ? 5'd1 : ((length_q > DEPTH5) ? DEPTH5 : length_q);
    assign last_step  = ({1'b0, idx_q} == (len_eff - 5'd1));

    assign busy         = (state_q == S_WRITE) || (state_q == S_WAIT);
    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wn_q;
    assign m_writedata  = 32'(m_wdat_q);

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        period_d  = period_q;
        length_d  = length_q;
        pat_d     = pat_q;
        if (cfg_wr) begin
            case (cfg_address)
                5'd0: begin
                    en_d      = cfg_writedata[0];
                    oneshot_d = cfg_writedata[1];
                end
                5'd1:    period_d = cfg_writedata[PERIOD_W-1:0];
                5'd2:    length_d = cfg_writedata[4:0];
                default: if (pat_hit) pat_d[pat_sel] = cfg_writedata[DATA_W-1:0];
            endcase
        end
    end

    // Sequencer reads pat_q/period_q (pre-write values) so a same-cycle slave write never alters the step.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        m_cs_d   = m_cs_q;
        m_wn_d   = m_wn_q;
        m_wdat_d = m_wdat_q;
        case (state_q)
            S_IDLE: begin
                if (en_eff) begin
                    state_d  = S_WRITE;
                    idx_d    = 4'd0;
                    done_d   = 1'b0;
                    m_cs_d   = 1'b1;
                    m_wn_d   = 1'b0;
                    m_wdat_d = pat_q[0];
                end
            end
            S_WRITE: begin
                if (!m_waitrequest) begin
                    m_cs_d  = 1'b0;
                    m_wn_d  = 1'b1;
                    cnt_d   = period_eff - PERIOD_ONE;
                    state_d = en_eff ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (!en_eff) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (last_step && oneshot_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_WRITE;
                        m_cs_d   = 1'b1;
                        m_wn_d   = 1'b0;
                        idx_d    = last_step ? 4'd0 : (idx_q + 4'd1);
                        m_wdat_d = last_step ? pat_q[0] : pat_q[IDX_W'(idx_q + 4'd1)];
                    end
                end else begin
                    cnt_d = cnt_q - PERIOD_ONE;
                end
            end
            S_DONE: begin
                if (ctrl_wr) begin
                    if (cfg_writedata[0]) begin
                        state_d  = S_WRITE;
                        idx_d    = 4'd0;
                        done_d   = 1'b0;
                        m_cs_d   = 1'b1;
                        m_wn_d   = 1'b0;
                        m_wdat_d = pat_q[0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            period_q  <= PERIOD_ONE;
            length_q  <= 5'd1;
            for (int i = 0; i < PATTERN_DEPTH; i++) pat_q[i] <= '0;
            idx_q     <= 4'd0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            m_cs_q    <= 1'b0;
            m_wn_q    <= 1'b1;
            m_wdat_q  <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            period_q  <= period_d;
            length_q  <= length_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            m_cs_q    <= m_cs_d;
            m_wn_q    <= m_wn_d;
            m_wdat_q  <= m_wdat_d;
        end
    end

    always_comb begin
        cfg_readdata = 32'd0;
        case (cfg_address)
            5'd0:    cfg_readdata = {30'd0, oneshot_q, en_q};
            5'd1:    cfg_readdata = 32'(period_q);
            5'd2:    cfg_readdata = {27'd0, length_q};
            5'd3:    cfg_readdata = {20'd0, idx_q, 6'd0, done_q, busy};
            default: if (pat_hit) cfg_readdata = 32'(pat_q[pat_sel]);
        endcase
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: register setup through the slave, pattern strobes observed on the master.
`timescale 1ns/1ps
module tb_led_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  cfg_address = 5'd0;
    logic        cfg_chipselect = 1'b0;
    logic        cfg_write_n = 1'b1;
    logic [31:0] cfg_writedata = 32'd0;
    logic [31:0] cfg_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int acc_cyc[$];
    logic [31:0] acc_dat[$];

    led_seq_ctrl #(.PATTERN_DEPTH(8), .PERIOD_W(24), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_address(cfg_address), .cfg_chipselect(cfg_chipselect), .cfg_write_n(cfg_write_n),
        .cfg_writedata(cfg_writedata), .cfg_readdata(cfg_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted master write with the cycle it completed in.
    always @(negedge clk) begin
        if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
            acc_cyc.push_back(cyc);
            acc_dat.push_back(m_writedata);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        cfg_address = addr;
        cfg_writedata = data;
        cfg_chipselect = 1'b1;
        cfg_write_n = 1'b0;
        last_wr_cyc = cyc;
        @(posedge clk);
        #1;
        cfg_chipselect = 1'b0;
        cfg_write_n = 1'b1;
    endtask

    task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
        cfg_address = addr;
        cfg_chipselect = 1'b1;
        cfg_write_n = 1'b1;
        #2;
        data = cfg_readdata;
        cfg_chipselect = 1'b0;
    endtask

    task automatic clear_log();
        acc_cyc.delete();
        acc_dat.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [4:0]  ra [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd23, 5'd4, 5'd31};
        logic [31:0] re [8] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        reset_n = 1'b0;
        wait_cycles(2);
        checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", m_chipselect); end
        checks++; if (m_write_n !== 1'b1) begin errors++; $display("FAIL reset_wn: got %b want 1", m_write_n); end
        checks++; if (m_writedata !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h want 0", m_writedata); end
        checks++; if (m_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", m_address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < 8; i++) begin
            cfg_read(ra[i], rd);
            checks++; if (rd !== re[i]) begin errors++; $display("FAIL reset_reg[%0d]: got %h want %h", ra[i], rd, re[i]); end
        end
        wait_cycles(1);
    endtask

    task automatic test_loop();
        logic [31:0] rd;
        logic [31:0] exp [5] = '{32'h01, 32'h02, 32'h04, 32'h01, 32'h02};
        int c;
        cfg_write(5'd16, 32'h01);
        cfg_write(5'd17, 32'h02);
        cfg_write(5'd18, 32'h04);
        cfg_write(5'd1, 32'd3);
        cfg_write(5'd2, 32'd3);
        clear_log();
        cfg_write(5'd0, 32'h1);
        c = last_wr_cyc;
        wait_cycles(10);
        cfg_read(5'd3, rd);
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL loop_status_busy: got %b want 1", rd[0]); end
        wait_cycles(8);
        checks++; if (acc_cyc.size() < 5) begin errors++; $display("FAIL loop_count: got %0d want >=5", acc_cyc.size()); end
        checks++; if (acc_cyc.size() < 1 || acc_cyc[0] != c + 1) begin errors++; $display("FAIL loop_first_latency: got cycle %0d want %0d", (acc_cyc.size() > 0) ? acc_cyc[0] : -1, c + 1); end
        for (int i = 0; i < 5 && i < acc_dat.size(); i++) begin
            checks++; if (acc_dat[i] !== exp[i]) begin errors++; $display("FAIL loop_data[%0d]: got %h want %h", i, acc_dat[i], exp[i]); end
        end
        for (int i = 0; i < 4 && i + 1 < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i+1] - acc_cyc[i] != 4) begin errors++; $display("FAIL loop_spacing[%0d]: got %0d want 4", i, acc_cyc[i+1] - acc_cyc[i]); end
        end
        cfg_write(5'd0, 32'h0);
        wait_cycles(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic [31:0] exp [3] = '{32'h01, 32'h02, 32'h04};
        clear_log();
        cfg_write(5'd0, 32'h3);
        wait_cycles(25);
        checks++; if (acc_dat.size() != 3) begin errors++; $display("FAIL oneshot_count: got %0d want 3", acc_dat.size()); end
        for (int i = 0; i < 3 && i < acc_dat.size(); i++) begin
            checks++; if (acc_dat[i] !== exp[i]) begin errors++; $display("FAIL oneshot_data[%0d]: got %h want %h", i, acc_dat[i], exp[i]); end
        end
        cfg_read(5'd3, rd);
        checks++; if (rd !== 32'h0202) begin errors++; $display("FAIL oneshot_status: got %h want 00000202", rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy: got %b want 0", busy); end
        checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL oneshot_cs: got %b want 0", m_chipselect); end
        checks++; if (m_writedata !== 32'h04) begin errors++; $display("FAIL oneshot_hold: got %h want 04", m_writedata); end
        cfg_write(5'd0, 32'h0);
        wait_cycles(2);
    endtask

    task automatic test_stall();
        int c;
        clear_log();
        cfg_write(5'd0, 32'h1);
        c = last_wr_cyc;
        wait_cycles(4);
        m_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 32'h02) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got cs=%b wn=%b wd=%h want cs=1 wn=0 wd=02", i, m_chipselect, m_write_n, m_writedata);
            end
            @(posedge clk);
            #1;
        end
        m_waitrequest = 1'b0;
        wait_cycles(6);
        checks++; if (acc_cyc.size() < 3) begin errors++; $display("FAIL stall_count: got %0d want >=3", acc_cyc.size()); end
        if (acc_cyc.size() >= 3) begin
            checks++; if (acc_cyc[1] != c + 10 || acc_dat[1] !== 32'h02) begin errors++; $display("FAIL stall_accept: got cycle %0d data %h want cycle %0d data 02", acc_cyc[1], acc_dat[1], c + 10); end
            checks++; if (acc_cyc[2] - acc_cyc[1] != 4 || acc_dat[2] !== 32'h04) begin errors++; $display("FAIL stall_gap: got gap %0d data %h want gap 4 data 04", acc_cyc[2] - acc_cyc[1], acc_dat[2]); end
        end
        cfg_write(5'd0, 32'h0);
        wait_cycles(3);
    endtask

    task automatic test_disable();
        clear_log();
        cfg_write(5'd0, 32'h1);
        wait_cycles(1);
        cfg_write(5'd0, 32'h0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_wait_busy: got %b want 0", busy); end
        wait_cycles(10);
        checks++; if (acc_cyc.size() != 1) begin errors++; $display("FAIL dis_wait_count: got %0d want 1", acc_cyc.size()); end
        clear_log();
        m_waitrequest = 1'b1;
        cfg_write(5'd0, 32'h1);
        wait_cycles(1);
        cfg_write(5'd0, 32'h0);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || m_chipselect !== 1'b1) begin errors++; $display("FAIL dis_write_hold: got busy=%b cs=%b want 1 1", busy, m_chipselect); end
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
        wait_cycles(1);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || m_chipselect !== 1'b0) begin errors++; $display("FAIL dis_write_idle: got busy=%b cs=%b want 0 0", busy, m_chipselect); end
        wait_cycles(10);
        checks++; if (acc_dat.size() != 1 || acc_dat[0] !== 32'h01) begin errors++; $display("FAIL dis_write_once: got %0d writes first %h want 1 write of 01", acc_dat.size(), (acc_dat.size() > 0) ? acc_dat[0] : 32'hx); end
    endtask

    task automatic test_bounds();
        cfg_write(5'd1, 32'd0);
        cfg_write(5'd2, 32'd0);
        cfg_write(5'd16, 32'hAA);
        clear_log();
        cfg_write(5'd0, 32'h1);
        wait_cycles(10);
        checks++; if (acc_cyc.size() < 4) begin errors++; $display("FAIL min_count: got %0d want >=4", acc_cyc.size()); end
        for (int i = 0; i < 4 && i < acc_dat.size(); i++) begin
            checks++; if (acc_dat[i] !== 32'hAA) begin errors++; $display("FAIL min_data[%0d]: got %h want aa", i, acc_dat[i]); end
        end
        for (int i = 0; i < 3 && i + 1 < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i+1] - acc_cyc[i] != 2) begin errors++; $display("FAIL min_spacing[%0d]: got %0d want 2", i, acc_cyc[i+1] - acc_cyc[i]); end
        end
        cfg_write(5'd0, 32'h0);
        wait_cycles(3);
        for (int i = 0; i < 8; i++) cfg_write(5'(16 + i), 32'h10 + i);
        cfg_write(5'd2, 32'd31);
        clear_log();
        cfg_write(5'd0, 32'h1);
        wait_cycles(20);
        checks++; if (acc_dat.size() < 9) begin errors++; $display("FAIL clamp_count: got %0d want >=9", acc_dat.size()); end
        for (int i = 0; i < 9 && i < acc_dat.size(); i++) begin
            checks++; if (acc_dat[i] !== 32'h10 + (i % 8)) begin errors++; $display("FAIL clamp_data[%0d]: got %h want %h", i, acc_dat[i], 32'h10 + (i % 8)); end
        end
        cfg_write(5'd0, 32'h0);
        wait_cycles(3);
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic [4:0]  ra [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16, 5'd19, 5'd23, 5'd5};
        logic [31:0] re [8] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        m_waitrequest = 1'b1;
        cfg_write(5'd0, 32'h1);
        #3;
        checks++; if (m_chipselect !== 1'b1) begin errors++; $display("FAIL arst_pre_cs: got %b want 1", m_chipselect); end
        reset_n = 1'b0;
        #1;
        checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_outputs: got cs=%b wn=%b wd=%h busy=%b want 0 1 0 0", m_chipselect, m_write_n, m_writedata, busy);
        end
        m_waitrequest = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        wait_cycles(1);
        cfg_write(5'd5, 32'hFF);
        cfg_write(5'd30, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            cfg_read(ra[i], rd);
            checks++; if (rd !== re[i]) begin errors++; $display("FAIL arst_reg[%0d]: got %h want %h", ra[i], rd, re[i]); end
        end
        cfg_read(5'd30, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h want 0", rd); end
        wait_cycles(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_oneshot();
        test_stall();
        test_disable();
        test_bounds();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
